// File: rtl/mimo_tx_channel.sv
// 2x2 MIMO transmit/channel model: maps four symbols (QPSK or 16-QAM) to a real 4x2 X matrix
// and computes Y = H*X + N in fixed point, using one shared multiplier, one MAC per cycle.
module mimo_tx_channel #(
  parameter int WIDTH    = 16,
  parameter int FBITS    = 8,
  parameter int LVL_QAM  = 81,
  parameter int LVL_QPSK = 181
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mod,
  input  logic [15:0]             sym,
  input  logic signed [WIDTH-1:0] h11, h12, h13, h14,
  input  logic signed [WIDTH-1:0] h21, h22, h23, h24,
  input  logic signed [WIDTH-1:0] h31, h32, h33, h34,
  input  logic signed [WIDTH-1:0] h41, h42, h43, h44,
  input  logic signed [WIDTH-1:0] n11, n12, n21, n22, n31, n32, n41, n42,
  output logic signed [WIDTH-1:0] y11, y12, y21, y22, y31, y32, y41, y42,
  output logic signed [WIDTH-1:0] sx11, sx12, sx21, sx22, sx31, sx32, sx41, sx42,
  output logic                    busy,
  output logic                    finish,
  output logic [2:0]              dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAP  = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int AW = 2 * WIDTH + 2;
  localparam int SW = AW - FBITS;

  localparam logic signed [WIDTH-1:0] QAM1 = WIDTH'(LVL_QAM);
  localparam logic signed [WIDTH-1:0] QAM3 = WIDTH'(3 * LVL_QAM);
  localparam logic signed [WIDTH-1:0] QPSK = WIDTH'(LVL_QPSK);
  localparam logic signed [SW:0] V_MAX = {{(SW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW:0] V_MIN = {{(SW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  // Gray-coded 16-QAM axis: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
  function automatic logic signed [WIDTH-1:0] qam_axis(input logic [1:0] b);
    case (b)
      2'b00:   qam_axis = -QAM3;
      2'b01:   qam_axis = -QAM1;
      2'b11:   qam_axis = QAM1;
      default: qam_axis = QAM3;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] map_axis(input logic m, input logic [1:0] qam_bits,
                                                       input logic qpsk_bit);
    map_axis = m ? qam_axis(qam_bits) : (qpsk_bit ? -QPSK : QPSK);
  endfunction

  logic signed [WIDTH-1:0] h_in [4][4];
  logic signed [WIDTH-1:0] n_in [4][2];

  assign h_in[0][0] = h11; assign h_in[0][1] = h12; assign h_in[0][2] = h13; assign h_in[0][3] = h14;
  assign h_in[1][0] = h21; assign h_in[1][1] = h22; assign h_in[1][2] = h23; assign h_in[1][3] = h24;
  assign h_in[2][0] = h31; assign h_in[2][1] = h32; assign h_in[2][2] = h33; assign h_in[2][3] = h34;
  assign h_in[3][0] = h41; assign h_in[3][1] = h42; assign h_in[3][2] = h43; assign h_in[3][3] = h44;
  assign n_in[0][0] = n11; assign n_in[0][1] = n12; assign n_in[1][0] = n21; assign n_in[1][1] = n22;
  assign n_in[2][0] = n31; assign n_in[2][1] = n32; assign n_in[3][0] = n41; assign n_in[3][1] = n42;

  logic [2:0]              state_q, state_d;
  logic                    mod_q, mod_d;
  logic [15:0]             sym_q, sym_d;
  logic signed [WIDTH-1:0] h_q [4][4];
  logic signed [WIDTH-1:0] h_d [4][4];
  logic signed [WIDTH-1:0] n_q [4][2];
  logic signed [WIDTH-1:0] n_d [4][2];
  logic signed [WIDTH-1:0] x_q [4][2];
  logic signed [WIDTH-1:0] x_d [4][2];
  logic signed [WIDTH-1:0] yb_q [4][2];
  logic signed [WIDTH-1:0] yb_d [4][2];
  logic signed [WIDTH-1:0] y_q [4][2];
  logic signed [WIDTH-1:0] y_d [4][2];
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [2:0]              k_q, k_d;
  logic [1:0]              m_q, m_d;
  logic                    busy_q, busy_d;
  logic                    finish_q, finish_d;

  // Element k walks Y column-major: row = k[1:0], slot = k[2]
  logic [1:0]              row;
  logic                    col;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [SW-1:0]    acc_sh;
  logic signed [SW:0]      v;
  logic signed [WIDTH-1:0] n_sel;
  logic signed [WIDTH-1:0] sat;

  assign row      = k_q[1:0];
  assign col      = k_q[2];
  assign prod     = h_q[row][m_q] * x_q[m_q][col];
  assign prod_ext = {{2{prod[2*WIDTH-1]}}, prod};
  assign acc_sh   = acc_q[AW-1:FBITS];
  assign n_sel    = n_q[row][col];
  assign v        = {acc_sh[SW-1], acc_sh} + {{(SW+1-WIDTH){n_sel[WIDTH-1]}}, n_sel};
  assign sat      = (v > V_MAX) ? V_MAX[WIDTH-1:0] : (v < V_MIN) ? V_MIN[WIDTH-1:0] : v[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    sym_d    = sym_q;
    h_d      = h_q;
    n_d      = n_q;
    x_d      = x_q;
    yb_d     = yb_q;
    y_d      = y_q;
    acc_d    = acc_q;
    k_d      = k_q;
    m_d      = m_q;
    busy_d   = busy_q;
    finish_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mod_d   = mod;
          sym_d   = sym;
          h_d     = h_in;
          n_d     = n_in;
          k_d     = 3'd0;
          m_d     = 2'd0;
          busy_d  = 1'b1;
          state_d = S_MAP;
        end
      end
      S_MAP: begin
        for (int j = 0; j < 2; j++) begin
          x_d[0][j] = map_axis(mod_q, sym_q[8*j+2 +: 2], sym_q[8*j+1]);
          x_d[1][j] = map_axis(mod_q, sym_q[8*j+6 +: 2], sym_q[8*j+5]);
          x_d[2][j] = map_axis(mod_q, sym_q[8*j   +: 2], sym_q[8*j]);
          x_d[3][j] = map_axis(mod_q, sym_q[8*j+4 +: 2], sym_q[8*j+4]);
        end
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = (m_q == 2'd0) ? prod_ext : acc_q + prod_ext;
        m_d   = m_q + 2'd1;
        if (m_q == 2'd3) state_d = S_WR;
      end
      S_WR: begin
        yb_d[row][col] = sat;
        if (k_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        // First DONE cycle publishes Y; the second holds off the next start by one cycle
        if (!finish_q) begin
          y_d      = yb_q;
          finish_d = 1'b1;
          busy_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mod_q    <= 1'b0;
      sym_q    <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      m_q      <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) h_q[i][j] <= '0;
        for (int j = 0; j < 2; j++) begin
          n_q[i][j]  <= '0;
          x_q[i][j]  <= '0;
          yb_q[i][j] <= '0;
          y_q[i][j]  <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      mod_q    <= mod_d;
      sym_q    <= sym_d;
      h_q      <= h_d;
      n_q      <= n_d;
      x_q      <= x_d;
      yb_q     <= yb_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      m_q      <= m_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign y11 = y_q[0][0]; assign y21 = y_q[1][0]; assign y31 = y_q[2][0]; assign y41 = y_q[3][0];
  assign y12 = y_q[0][1]; assign y22 = y_q[1][1]; assign y32 = y_q[2][1]; assign y42 = y_q[3][1];
  assign sx11 = x_q[0][0]; assign sx21 = x_q[1][0]; assign sx31 = x_q[2][0]; assign sx41 = x_q[3][0];
  assign sx12 = x_q[0][1]; assign sx22 = x_q[1][1]; assign sx32 = x_q[2][1]; assign sx42 = x_q[3][1];
  assign busy      = busy_q;
  assign finish    = finish_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mimo_tx_channel.sv
// Directed bench for mimo_tx_channel: driver pushes hand-computed Y/X/latency expectations,
// a negedge monitor pops and compares them whenever finish is seen.
module tb_mimo_tx_channel;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mod = 1'b0;
  logic [15:0] sym = '0;
  logic signed [W-1:0] h [4][4];
  logic signed [W-1:0] n [4][2];
  logic signed [W-1:0] y [4][2];
  logic signed [W-1:0] sx [4][2];
  logic busy, finish;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int finish_seen = 0;
  logic prev_fin = 1'b0;

  // Each entry: 8 elements packed column-major (y11,y21,y31,y41,y12,...,y42), element e at [16e +: 16]
  logic [8*W-1:0] exp_q[$];
  logic [8*W-1:0] exp_sx_q[$];
  int             exp_lat_q[$];

  mimo_tx_channel dut (
    .clk(clk), .reset(reset), .start(start), .mod(mod), .sym(sym),
    .h11(h[0][0]), .h12(h[0][1]), .h13(h[0][2]), .h14(h[0][3]),
    .h21(h[1][0]), .h22(h[1][1]), .h23(h[1][2]), .h24(h[1][3]),
    .h31(h[2][0]), .h32(h[2][1]), .h33(h[2][2]), .h34(h[2][3]),
    .h41(h[3][0]), .h42(h[3][1]), .h43(h[3][2]), .h44(h[3][3]),
    .n11(n[0][0]), .n12(n[0][1]), .n21(n[1][0]), .n22(n[1][1]),
    .n31(n[2][0]), .n32(n[2][1]), .n41(n[3][0]), .n42(n[3][1]),
    .y11(y[0][0]), .y12(y[0][1]), .y21(y[1][0]), .y22(y[1][1]),
    .y31(y[2][0]), .y32(y[2][1]), .y41(y[3][0]), .y42(y[3][1]),
    .sx11(sx[0][0]), .sx12(sx[0][1]), .sx21(sx[1][0]), .sx22(sx[1][1]),
    .sx31(sx[2][0]), .sx32(sx[2][1]), .sx41(sx[3][0]), .sx42(sx[3][1]),
    .busy(busy), .finish(finish), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8*W-1:0] pack8(input int v[8]);
    logic [8*W-1:0] r;
    int t;
    for (int e = 0; e < 8; e++) begin
      t = v[e];
      r[e*W +: W] = t[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [8*W-1:0] fill8(input int val);
    int v[8];
    for (int e = 0; e < 8; e++) v[e] = val;
    return pack8(v);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset && finish) begin
      logic [8*W-1:0] ey, es;
      int el;
      finish_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_finish", 1, 0);
      end else begin
        ey = exp_q.pop_front();
        es = exp_sx_q.pop_front();
        el = exp_lat_q.pop_front();
        check("finish_latency", cyc, el);
        check("busy_at_finish", int'(busy), 0);
        for (int e = 0; e < 8; e++) begin
          check($sformatf("y%0d%0d", e % 4 + 1, e / 4 + 1), int'(y[e % 4][e / 4]),
                int'($signed(ey[e*W +: W])));
          check($sformatf("sx%0d%0d", e % 4 + 1, e / 4 + 1), int'(sx[e % 4][e / 4]),
                int'($signed(es[e*W +: W])));
        end
      end
    end
    if (reset && prev_fin) check("finish_one_cycle", int'(finish), 0);
    prev_fin <= reset && finish;
  end

  // Driver tasks
  task automatic set_h_diag(input int val);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) h[i][j] = (i == j) ? W'(val) : '0;
  endtask

  task automatic set_h_all(input int val);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) h[i][j] = W'(val);
  endtask

  task automatic clear_n();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) n[i][j] = '0;
  endtask

  // Issues one start pulse; returns the cycle count right after the sampling edge E0
  task automatic issue(input logic m, input logic [15:0] s, input logic push,
                       input logic [8*W-1:0] ey, input logic [8*W-1:0] es, output int c0);
    @(negedge clk);
    mod = m;
    sym = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    if (push) begin
      exp_q.push_back(ey);
      exp_sx_q.push_back(es);
      exp_lat_q.push_back(c0 + 42);
    end
  endtask

  task automatic wait_done();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      check("finish_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_sx_q.delete();
      exp_lat_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_frame(input logic m, input logic [15:0] s,
                           input logic [8*W-1:0] ey, input logic [8*W-1:0] es);
    int c0;
    issue(m, s, 1'b1, ey, es, c0);
    check("busy_after_start", int'(busy), 1);
    wait_done();
  endtask

  initial begin
    int c0, f0;
    int v[8];
    set_h_all(0);
    clear_n();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_state", int'(dbg_state), 0);
    check("rst_y11", int'(y[0][0]), 0);
    check("rst_sx42", int'(sx[3][1]), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Identity channel (256 = 1.0), 16-QAM +3/+3 everywhere
    set_h_diag(256);
    run_frame(1'b1, 16'hAAAA, fill8(243), fill8(243));

    // Full-scale channel drives both saturation rails
    set_h_all(16'h7FFF);
    run_frame(1'b1, 16'hAAAA, fill8(32767), fill8(243));
    run_frame(1'b1, 16'h0000, fill8(-32768), fill8(-243));

    // Half-gain channel, QPSK: floor(+-90.5)
    set_h_diag(128);
    run_frame(1'b0, 16'h0000, fill8(90), fill8(181));
    run_frame(1'b0, 16'h3333, fill8(-91), fill8(-181));

    // Zero channel: Y is exactly N
    set_h_all(0);
    n[0][0] = 16'sd100;
    n[3][1] = -16'sd5;
    v = '{100, 0, 0, 0, 0, 0, 0, -5};
    run_frame(1'b1, 16'hAAAA, pack8(v), fill8(243));
    clear_n();

    // Mixed 16-QAM symbols with a second start and input churn mid-frame
    set_h_diag(256);
    v = '{81, -243, -243, -243, 81, -81, 81, -81};
    f0 = finish_seen;
    issue(1'b1, 16'h5F0C, 1'b1, pack8(v), pack8(v), c0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    sym = 16'h0000;
    set_h_all(16'h1234);
    n[1][1] = 16'sd77;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check("single_finish", finish_seen - f0, 1);
    clear_n();
    set_h_diag(256);

    // Back-to-back: start held high for two frames, 44 cycles apart
    @(negedge clk);
    mod = 1'b1;
    sym = 16'hAAAA;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    exp_q.push_back(fill8(243));
    exp_sx_q.push_back(fill8(243));
    exp_lat_q.push_back(c0 + 42);
    repeat (44) @(posedge clk);
    #1;
    exp_q.push_back(fill8(243));
    exp_sx_q.push_back(fill8(243));
    exp_lat_q.push_back(c0 + 44 + 42);
    start = 1'b0;
    wait_done();

    // Reset asserted at cycle 20 of a frame: everything clears, no finish
    f0 = finish_seen;
    issue(1'b0, 16'h3333, 1'b0, '0, '0, c0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_finish", int'(finish), 0);
    check("mid_rst_y11", int'(y[0][0]), 0);
    check("mid_rst_y42", int'(y[3][1]), 0);
    check("mid_rst_sx11", int'(sx[0][0]), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(posedge clk);
    check("mid_rst_no_finish", finish_seen - f0, 0);

    // Recovery frame, QPSK mixed signs through identity channel
    v = '{-181, 181, 181, -181, -181, 181, 181, -181};
    run_frame(1'b0, 16'h1212, pack8(v), pack8(v));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
